// File: rtl/req_ack_checker.sv
// Passive multi-channel req/ack protocol monitor: tracks outstanding requests per
// channel and reports spurious acks, overflow, timeout, data changes and multiple acks.
module req_ack_checker #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 32,
  parameter int MAX_OUTST    = 1,
  parameter int TIMEOUT      = 16,
  parameter int SAME_CYC_ACK = 0,
  parameter int AMONE_ACK    = 1,
  parameter int STABLE_CHK   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     check_en,
  input  logic                     clr,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          ack,
  input  logic [N_CH*DATA_W-1:0]   data,
  output logic [N_CH-1:0]          busy,
  output logic                     err_valid,
  output logic [2:0]               err_code,
  output logic [3:0]               err_ch,
  output logic [N_CH-1:0]          err_sticky,
  output logic                     err_multi,
  output logic [15:0]              err_count
);

  typedef logic [N_CH-1:0] ch_vec_t;

  localparam logic [2:0]  CODE_NONE  = 3'd0;
  localparam logic [2:0]  CODE_ANR   = 3'd1;
  localparam logic [2:0]  CODE_OVF   = 3'd2;
  localparam logic [2:0]  CODE_TMO   = 3'd3;
  localparam logic [2:0]  CODE_DCHG  = 3'd4;
  localparam logic [2:0]  CODE_MULTI = 3'd5;
  localparam logic [3:0]  MAX_OUT_C  = 4'(MAX_OUTST);
  // Age counts completed waiting cycles, so the current cycle makes it TIMEOUT.
  localparam logic [15:0] TMO_AGE_C  = 16'(TIMEOUT - 1);
  localparam bit          SAME_ACK_C = (SAME_CYC_ACK != 0);
  localparam bit          AMONE_C    = (AMONE_ACK != 0);
  localparam bit          DATA_CHK_C = (STABLE_CHK != 0) && (MAX_OUTST == 1);

  function automatic logic more_than_one(input ch_vec_t v);
    return (v & (v - ch_vec_t'(1))) != ch_vec_t'(0);
  endfunction

  logic [3:0]        out_r     [N_CH];
  logic [15:0]       age_r     [N_CH];
  logic [DATA_W-1:0] cap_r     [N_CH];
  ch_vec_t           fired_r;

  logic [3:0]        out_nxt_s [N_CH];
  logic [15:0]       age_nxt_s [N_CH];
  logic [DATA_W-1:0] cap_nxt_s [N_CH];
  logic [2:0]        ch_code_s [N_CH];
  ch_vec_t           fired_nxt_s;
  ch_vec_t           busy_nxt_s;
  ch_vec_t           anr_s;
  ch_vec_t           ovf_s;
  ch_vec_t           tmo_s;
  ch_vec_t           dchg_s;
  ch_vec_t           ch_err_s;
  logic              multi_s;
  logic              any_err_s;
  logic [2:0]        rpt_code_s;
  logic [3:0]        rpt_ch_s;

  // Per-channel violation detection and next-state tracking
  always_comb begin
    anr_s       = '0;
    ovf_s       = '0;
    tmo_s       = '0;
    dchg_s      = '0;
    ch_err_s    = '0;
    fired_nxt_s = '0;
    busy_nxt_s  = '0;
    for (int c = 0; c < N_CH; c++) begin
      out_nxt_s[c] = out_r[c];
      age_nxt_s[c] = age_r[c];
      cap_nxt_s[c] = cap_r[c];
      ch_code_s[c] = CODE_NONE;

      anr_s[c]  = ack[c] && (out_r[c] == 4'd0) && !(SAME_ACK_C && req[c]);
      ovf_s[c]  = req[c] && !ack[c] && (out_r[c] == MAX_OUT_C);
      tmo_s[c]  = (out_r[c] != 4'd0) && (age_r[c] >= TMO_AGE_C) && !fired_r[c];
      dchg_s[c] = DATA_CHK_C && (out_r[c] == 4'd1) && !ack[c] &&
                  (data[c*DATA_W +: DATA_W] != cap_r[c]);

      if (anr_s[c]) begin
        out_nxt_s[c] = out_r[c] + {3'b000, req[c]};
      end else if (ovf_s[c]) begin
        out_nxt_s[c] = out_r[c];
      end else begin
        out_nxt_s[c] = out_r[c] + {3'b000, req[c]} - {3'b000, ack[c]};
      end

      if (ack[c] || (req[c] && (out_r[c] == 4'd0))) begin
        age_nxt_s[c] = 16'd0;
      end else if ((out_r[c] != 4'd0) && (age_r[c] != 16'hFFFF)) begin
        age_nxt_s[c] = age_r[c] + 16'd1;
      end else begin
        age_nxt_s[c] = age_r[c];
      end

      // Timeout re-arms on progress (ack) or when the channel drains
      if (ack[c] || (out_nxt_s[c] == 4'd0)) begin
        fired_nxt_s[c] = 1'b0;
      end else if (tmo_s[c]) begin
        fired_nxt_s[c] = 1'b1;
      end else begin
        fired_nxt_s[c] = fired_r[c];
      end

      if (req[c] && !ovf_s[c]) begin
        cap_nxt_s[c] = data[c*DATA_W +: DATA_W];
      end else begin
        cap_nxt_s[c] = cap_r[c];
      end

      if (!check_en) begin
        ch_code_s[c] = CODE_NONE;
      end else if (anr_s[c]) begin
        ch_code_s[c] = CODE_ANR;
      end else if (ovf_s[c]) begin
        ch_code_s[c] = CODE_OVF;
      end else if (tmo_s[c]) begin
        ch_code_s[c] = CODE_TMO;
      end else if (dchg_s[c]) begin
        ch_code_s[c] = CODE_DCHG;
      end else begin
        ch_code_s[c] = CODE_NONE;
      end

      ch_err_s[c]   = (ch_code_s[c] != CODE_NONE);
      busy_nxt_s[c] = (out_nxt_s[c] != 4'd0);
    end
  end

  // Error prioritisation: multi-ack, then lowest channel, then lowest code
  always_comb begin
    multi_s    = check_en && AMONE_C && more_than_one(ack);
    any_err_s  = multi_s || (ch_err_s != ch_vec_t'(0));
    rpt_code_s = CODE_NONE;
    rpt_ch_s   = 4'd0;
    if (multi_s) begin
      rpt_code_s = CODE_MULTI;
      rpt_ch_s   = 4'd0;
    end else begin
      for (int c = N_CH - 1; c >= 0; c--) begin
        rpt_code_s = ch_err_s[c] ? ch_code_s[c] : rpt_code_s;
        rpt_ch_s   = ch_err_s[c] ? 4'(c) : rpt_ch_s;
      end
    end
  end

  // Channel tracking state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        out_r[c] <= 4'd0;
        age_r[c] <= 16'd0;
        cap_r[c] <= '0;
      end
      fired_r <= '0;
      busy    <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        out_r[c] <= out_nxt_s[c];
        age_r[c] <= age_nxt_s[c];
        cap_r[c] <= cap_nxt_s[c];
      end
      fired_r <= fired_nxt_s;
      busy    <= busy_nxt_s;
    end
  end

  // Registered error report, sticky status and saturating error counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid  <= 1'b0;
      err_code   <= 3'd0;
      err_ch     <= 4'd0;
      err_sticky <= '0;
      err_multi  <= 1'b0;
      err_count  <= 16'd0;
    end else begin
      err_valid <= any_err_s;
      err_code  <= rpt_code_s;
      err_ch    <= rpt_ch_s;
      if (clr) begin
        err_sticky <= '0;
        err_multi  <= 1'b0;
        err_count  <= 16'd0;
      end else begin
        err_sticky <= err_sticky | ch_err_s;
        err_multi  <= err_multi | multi_s;
        if (any_err_s && (err_count != 16'hFFFF)) begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_req_ack_checker.sv
// Directed self-checking bench for req_ack_checker with default parameters
// (4 channels, MAX_OUTST=1, TIMEOUT=16, SAME_CYC_ACK=0, AMONE_ACK=1, STABLE_CHK=1).
module tb_req_ack_checker;

  logic         clk;
  logic         reset;
  logic         check_en;
  logic         clr;
  logic [3:0]   req;
  logic [3:0]   ack;
  logic [127:0] data;
  logic [3:0]   busy;
  logic         err_valid;
  logic [2:0]   err_code;
  logic [3:0]   err_ch;
  logic [3:0]   err_sticky;
  logic         err_multi;
  logic [15:0]  err_count;

  int checks;
  int failures;

  req_ack_checker dut (
    .clk        (clk),
    .reset      (reset),
    .check_en   (check_en),
    .clr        (clr),
    .req        (req),
    .ack        (ack),
    .data       (data),
    .busy       (busy),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_ch     (err_ch),
    .err_sticky (err_sticky),
    .err_multi  (err_multi),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, 4'b0000); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL reset_err_valid got=%b exp=0", err_valid); end
    checks++; if (err_code !== 3'd0) begin failures++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
    checks++; if (err_ch !== 4'd0) begin failures++; $display("FAIL reset_err_ch got=%0d exp=0", err_ch); end
    checks++; if (err_sticky !== 4'b0000) begin failures++; $display("FAIL reset_sticky got=%b exp=0000", err_sticky); end
    checks++; if (err_multi !== 1'b0) begin failures++; $display("FAIL reset_multi got=%b exp=0", err_multi); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", err_count); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    data[31:0] = 32'h0000FEED;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    checks++; if (busy !== 4'b0001) begin failures++; $display("FAIL basic_busy_a got=%b exp=0001", busy); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL basic_err_a got=%b exp=0", err_valid); end
    tick();
    checks++; if (busy !== 4'b0001) begin failures++; $display("FAIL basic_busy_b got=%b exp=0001", busy); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL basic_err_b got=%b exp=0", err_valid); end
    ack = 4'b0001;
    tick();
    ack = 4'b0000;
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL basic_busy_c got=%b exp=0000", busy); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL basic_err_c got=%b exp=0", err_valid); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL basic_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_ack_no_req();
    pulse_clr();
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL anr_valid got=%b exp=1", err_valid); end
    checks++; if (err_code !== 3'd1) begin failures++; $display("FAIL anr_code got=%0d exp=1", err_code); end
    checks++; if (err_ch !== 4'd2) begin failures++; $display("FAIL anr_ch got=%0d exp=2", err_ch); end
    checks++; if (err_sticky !== 4'b0100) begin failures++; $display("FAIL anr_sticky got=%b exp=0100", err_sticky); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL anr_count got=%0d exp=1", err_count); end
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL anr_busy got=%b exp=0000", busy); end
    tick();
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL anr_pulse got=%b exp=0", err_valid); end
  endtask

  task automatic test_timeout();
    int first_i;
    int pulses;
    logic [2:0] code_seen;
    logic [3:0] ch_seen;
    first_i   = 0;
    pulses    = 0;
    code_seen = 3'd0;
    ch_seen   = 4'd0;
    pulse_clr();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (err_valid === 1'b1) begin
        pulses++;
        if (first_i == 0) begin
          first_i   = i;
          code_seen = err_code;
          ch_seen   = err_ch;
        end
      end
    end
    checks++; if (first_i != 16) begin failures++; $display("FAIL tmo_latency got=%0d exp=16", first_i); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL tmo_pulses got=%0d exp=1", pulses); end
    checks++; if (code_seen !== 3'd3) begin failures++; $display("FAIL tmo_code got=%0d exp=3", code_seen); end
    checks++; if (ch_seen !== 4'd1) begin failures++; $display("FAIL tmo_ch got=%0d exp=1", ch_seen); end
    checks++; if (busy !== 4'b0010) begin failures++; $display("FAIL tmo_busy got=%b exp=0010", busy); end
    ack = 4'b0010;
    tick();
    ack = 4'b0000;
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL tmo_ack_busy got=%b exp=0000", busy); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL tmo_ack_err got=%b exp=0", err_valid); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL tmo_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_overflow();
    pulse_clr();
    data[31:0] = 32'h0000FEED;
    req = 4'b0001;
    tick();
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL ovf_first got=%b exp=0", err_valid); end
    tick();
    req = 4'b0001;
    ack = 4'b0001;
    checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", err_valid); end
    checks++; if (err_code !== 3'd2) begin failures++; $display("FAIL ovf_code got=%0d exp=2", err_code); end
    checks++; if (err_ch !== 4'd0) begin failures++; $display("FAIL ovf_ch got=%0d exp=0", err_ch); end
    checks++; if (busy !== 4'b0001) begin failures++; $display("FAIL ovf_busy got=%b exp=0001", busy); end
    tick();
    req = 4'b0000;
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL ovf_reqack_err got=%b exp=0", err_valid); end
    checks++; if (busy !== 4'b0001) begin failures++; $display("FAIL ovf_reqack_busy got=%b exp=0001", busy); end
    tick();
    ack = 4'b0000;
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL ovf_drain_busy got=%b exp=0000", busy); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL ovf_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_data_chg();
    pulse_clr();
    data[31:0] = 32'h0000FEED;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    data[31:0] = 32'h00000000;
    tick();
    checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL dchg_valid_a got=%b exp=1", err_valid); end
    checks++; if (err_code !== 3'd4) begin failures++; $display("FAIL dchg_code_a got=%0d exp=4", err_code); end
    tick();
    checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL dchg_valid_b got=%b exp=1", err_valid); end
    checks++; if (err_code !== 3'd4) begin failures++; $display("FAIL dchg_code_b got=%0d exp=4", err_code); end
    ack = 4'b0001;
    tick();
    ack = 4'b0000;
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL dchg_ack_err got=%b exp=0", err_valid); end
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL dchg_busy got=%b exp=0000", busy); end
    checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL dchg_count got=%0d exp=2", err_count); end
  endtask

  task automatic test_multi_ack();
    pulse_clr();
    req = 4'b1010;
    tick();
    req = 4'b0000;
    ack = 4'b1010;
    tick();
    ack = 4'b0000;
    checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL multi_valid got=%b exp=1", err_valid); end
    checks++; if (err_code !== 3'd5) begin failures++; $display("FAIL multi_code got=%0d exp=5", err_code); end
    checks++; if (err_ch !== 4'd0) begin failures++; $display("FAIL multi_ch got=%0d exp=0", err_ch); end
    checks++; if (err_multi !== 1'b1) begin failures++; $display("FAIL multi_flag got=%b exp=1", err_multi); end
    checks++; if (err_sticky !== 4'b0000) begin failures++; $display("FAIL multi_sticky got=%b exp=0000", err_sticky); end
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL multi_busy got=%b exp=0000", busy); end
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    checks++; if (err_sticky !== 4'b0100) begin failures++; $display("FAIL multi_anr_sticky got=%b exp=0100", err_sticky); end
    checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL multi_anr_count got=%0d exp=2", err_count); end
    // clear coinciding with a fresh error: cleared result, error still pulsed
    clr = 1'b1;
    ack = 4'b0001;
    tick();
    clr = 1'b0;
    ack = 4'b0000;
    checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL clr_err_valid got=%b exp=1", err_valid); end
    checks++; if (err_ch !== 4'd0) begin failures++; $display("FAIL clr_err_ch got=%0d exp=0", err_ch); end
    checks++; if (err_sticky !== 4'b0000) begin failures++; $display("FAIL clr_sticky got=%b exp=0000", err_sticky); end
    checks++; if (err_multi !== 1'b0) begin failures++; $display("FAIL clr_multi got=%b exp=0", err_multi); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_check_en();
    check_en = 1'b0;
    ack = 4'b1000;
    tick();
    ack = 4'b0000;
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL chken_valid got=%b exp=0", err_valid); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL chken_count got=%0d exp=0", err_count); end
    check_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    checks++; if (busy !== 4'b0010) begin failures++; $display("FAIL rmid_busy_a got=%b exp=0010", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL rmid_busy_b got=%b exp=0000", busy); end
    check_en = 1'b0;
    ack = 4'b0010;
    tick();
    ack = 4'b0000;
    check_en = 1'b1;
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", err_valid); end
    tick();
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    req = 4'b0001;
    tick();
    for (int k = 0; k < 3; k++) begin
      ack = 4'b0001;
      tick();
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL b2b_err_%0d got=%b exp=0", k, err_valid); end
      checks++; if (busy !== 4'b0001) begin failures++; $display("FAIL b2b_busy_%0d got=%b exp=0001", k, busy); end
    end
    req = 4'b0000;
    tick();
    ack = 4'b0000;
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL b2b_drain got=%b exp=0000", busy); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL b2b_count got=%0d exp=0", err_count); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    check_en = 1'b1;
    clr      = 1'b0;
    req      = 4'b0000;
    ack      = 4'b0000;
    data     = '0;
    test_reset();
    test_basic();
    test_ack_no_req();
    test_timeout();
    test_overflow();
    test_data_chg();
    test_multi_ack();
    test_check_en();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_ack_checker.md
Name: req_ack_checker

Overview:
Synthesizable multi-channel request/acknowledge protocol monitor. It is the hardware successor to the simulation-only single-channel req/ack assertion. It sits passively beside a bus arbiter or slave and tracks outstanding requests per channel. It flags protocol violations (spurious ack, overflow, timeout, data change, multiple acks) through a registered error report, sticky status bits and a saturating error counter.

Parameters:
N_CH, 4, number of independent req/ack channels (1..16)
DATA_W, 32, request data width per channel
MAX_OUTST, 1, max outstanding requests per channel (1..15)
TIMEOUT, 16, cycles without progress before timeout error (2..65535)
SAME_CYC_ACK, 0, 1 = ack in same cycle as req with zero outstanding is legal
AMONE_ACK, 1, 1 = at most one channel may ack per cycle
STABLE_CHK, 1, 1 = data must hold from req until its ack (only when MAX_OUTST==1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
check_en  in  1  1 = checks active; 0 = tracking continues, no errors raised
clr  in  1  synchronous clear of err_sticky, err_multi, err_count
req  in  N_CH  single-cycle request pulse per channel
ack  in  N_CH  single-cycle acknowledge pulse per channel
data  in  N_CH*DATA_W  request data, channel c at [c*DATA_W +: DATA_W]
busy  out  N_CH  channel has outstanding requests
err_valid  out  1  one-cycle pulse, error detected last cycle
err_code  out  3  1 ACK_NO_REQ, 2 OVERFLOW, 3 TIMEOUT, 4 DATA_CHG, 5 MULTI_ACK
err_ch  out  4  channel of reported error (0 for MULTI_ACK)
err_sticky  out  N_CH  per-channel error seen since reset/clr
err_multi  out  1  MULTI_ACK seen since reset/clr
err_count  out  16  cycles with at least one error, saturates at 16'hFFFF

Behaviour:
- Reset: all outputs 0; all outstanding counts, age counters, timeout-fired flags and captured data are 0.
- Per-channel outstanding count out[c], 4 bits: next = out + req - ack, with the following exceptions.
  - ACK_NO_REQ: ack with out==0 and not (SAME_CYC_ACK && req). Error; count takes +req only.
  - OVERFLOW: req && !ack && out==MAX_OUTST. Error; count unchanged.
  - req && ack with out==MAX_OUTST is legal; net 0.
- Age counter per channel (16 bits):
  - Cleared on any ack, and on a req when out==0.
  - Increments each cycle while out!=0.
- TIMEOUT: age reaches TIMEOUT with out!=0. Fires once, then is suppressed until the next ack or until out returns to 0.
- DATA_CHG (STABLE_CHK && MAX_OUTST==1): data is captured on an accepted req. Error on any cycle where out==1, no ack, and data != captured. Fires every such cycle.
- MULTI_ACK (AMONE_ACK): more than one ack bit set in a cycle. Per-channel checks still run.
- Detection is combinational on the sampled inputs; reporting is registered, so err_valid is asserted the cycle after the offending edge.
- Multiple errors in one cycle:
  - err_code/err_ch report the highest priority: MULTI_ACK first, then lowest channel, then lowest code.
  - All offending channels set their err_sticky bits.
  - err_count increments by 1 only.
- check_en=0: no error detection; counters, ages and captures still update.
- clr takes priority over a same-cycle error increment: the result is cleared, and the error is still pulsed on err_valid.
- busy[c] = (out[c]!=0), registered.
- Reset asserted mid-transaction: all tracking is lost. Acks after reset release produce ACK_NO_REQ (intended; the bench must gate with check_en).

Test Plan:
- Ch0 req at cycle 1 with data=32'hFEED, ack at cycle 3 (data held) -> busy[0]=1 in cycles 2-3; no err_valid; err_count=0.
- Ch2 ack with no prior req -> err_valid=1 next cycle, err_code=1, err_ch=2, err_sticky=4'b0100, err_count=1.
- Ch1 req, no ack, TIMEOUT=16 -> single err_valid with err_code=3, err_ch=1, 16 cycles after req; no repeat; a later ack clears busy[1].
- MAX_OUTST=1: ch0 req twice without ack -> err_code=2 on the second; a req+ack on the same full cycle -> no error.
- Ch0 req data=32'hFEED, data changes to 32'h0 before ack -> err_code=4 each cycle until ack.
- Ch1 and ch3 ack together, both outstanding -> err_code=5, err_ch=0, err_multi=1. Then clr -> err_sticky=0, err_multi=0, err_count=0.
